// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM read/write arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W   = 24;   // {bank_sel, offset}
    localparam int OFFSET_W = 23;   // word offset within a frame
    localparam int BURST_W  = 10;   // burst length field width

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_BUSY = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_BUSY = 3'd4
    } arb_state_t;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dir_t;

endpackage

// File: rtl/sdram_addr_gen.sv
// Frame offset counter: advances by one burst at each burst end, wraps
// from MAX back to MIN with a one-cycle frame_done pulse, and handles
// restart requests (immediate when idle, deferred to burst end when busy).
module sdram_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter logic [BURST_W-1:0]  BURST    = 10'd256,
    parameter logic [OFFSET_W-1:0] MIN_ADDR = 23'd0,
    parameter logic [OFFSET_W-1:0] MAX_ADDR = 23'd384000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,        // restart request pulse
    input  logic                active,      // own direction in REQ/BUSY
    input  logic                burst_end,   // ack falling edge of own burst
    output logic [OFFSET_W-1:0] offset,
    output logic                frame_done,
    output logic                wrap_now,    // wrap takes effect this edge
    output logic                restart_now  // restart takes effect this edge
);

    logic [OFFSET_W-1:0] offset_reg;
    logic                pending_reg;
    logic                frame_done_reg;
    logic [OFFSET_W:0]   nxt;

    // Next offset and the events that apply on the coming edge
    always_comb begin
        nxt         = {1'b0, offset_reg} + {{(OFFSET_W + 1 - BURST_W){1'b0}}, BURST};
        wrap_now    = burst_end && (nxt >= {1'b0, MAX_ADDR});
        restart_now = burst_end ? (load || pending_reg) : (load && !active);
    end

    // Offset register; a restart overrides the increment but not the wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_reg     <= MIN_ADDR;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= wrap_now;
            if (burst_end) begin
                pending_reg <= 1'b0;
                if (restart_now || wrap_now) begin
                    offset_reg <= MIN_ADDR;
                end else begin
                    offset_reg <= nxt[OFFSET_W-1:0];
                end
            end else if (restart_now) begin
                offset_reg <= MIN_ADDR;
            end else if (load && active) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign offset     = offset_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Shares one SDRAM controller between the write-side and read-side FIFOs,
// issuing burst requests with auto-incrementing, frame-wrapping addresses.
// Optional feature: define SDRAM_PINGPONG_EN to use address bit 23 as a
// double-buffer bank selector (read always targets the bank not being written).
module sdram_rw_arbiter
    import sdram_arb_pkg::*;
#(
    parameter logic [9:0]  WR_BURST      = 10'd256,
    parameter logic [9:0]  RD_BURST      = 10'd256,
    parameter logic [10:0] RD_FIFO_DEPTH = 11'd1024,
    parameter logic [22:0] WR_MIN_ADDR   = 23'd0,
    parameter logic [22:0] WR_MAX_ADDR   = 23'd384000,
    parameter logic [22:0] RD_MIN_ADDR   = 23'd0,
    parameter logic [22:0] RD_MAX_ADDR   = 23'd384000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic [9:0]  wr_fifo_level,
    input  logic [10:0] rd_fifo_level,
    input  logic        rd_enable,
    input  logic        wr_load,
    input  logic        rd_load,
    output logic        sdram_wr_req,
    input  logic        sdram_wr_ack,
    output logic [23:0] sdram_wr_addr,
    output logic [9:0]  sdram_wr_burst,
    output logic        sdram_rd_req,
    input  logic        sdram_rd_ack,
    output logic [23:0] sdram_rd_addr,
    output logic [9:0]  sdram_rd_burst,
    output logic        wr_frame_done,
    output logic        rd_frame_done
);

    // Highest read FIFO fill that still leaves room for a whole burst
    localparam logic [10:0] RD_OK_LIMIT = RD_FIFO_DEPTH - {1'b0, RD_BURST};

    arb_state_t          state_reg, state_next;
    dir_t                last_served_reg;
    logic                wr_req_reg, wr_req_next;
    logic                rd_req_reg, rd_req_next;
    logic                wr_ok, rd_ok;
    logic                wr_active, rd_active;
    logic                wr_burst_end, rd_burst_end;
    logic [OFFSET_W-1:0] wr_offset, rd_offset;
    logic                wr_wrap_now, wr_restart_now;
    logic                rd_wrap_now, rd_restart_now;

    assign wr_ok        = (wr_fifo_level >= WR_BURST);
    assign rd_ok        = rd_enable && (rd_fifo_level <= RD_OK_LIMIT);
    assign wr_active    = (state_reg == ST_WR_REQ) || (state_reg == ST_WR_BUSY);
    assign rd_active    = (state_reg == ST_RD_REQ) || (state_reg == ST_RD_BUSY);
    // BUSY is only entered with ack high, so ack low in BUSY is the falling edge
    assign wr_burst_end = (state_reg == ST_WR_BUSY) && !sdram_wr_ack;
    assign rd_burst_end = (state_reg == ST_RD_BUSY) && !sdram_rd_ack;

    // State register with registered request outputs and round-robin memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            last_served_reg <= DIR_READ;
            wr_req_reg      <= 1'b0;
            rd_req_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_req_reg <= wr_req_next;
            rd_req_reg <= rd_req_next;
            if (state_reg == ST_IDLE && state_next == ST_WR_REQ) begin
                last_served_reg <= DIR_WRITE;
            end else if (state_reg == ST_IDLE && state_next == ST_RD_REQ) begin
                last_served_reg <= DIR_READ;
            end
        end
    end

    // Next-state: grant in IDLE, follow the ack handshake otherwise
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sdram_init_done) begin
                    if (wr_ok && rd_ok) begin
                        state_next = (last_served_reg == DIR_READ) ? ST_WR_REQ : ST_RD_REQ;
                    end else if (wr_ok) begin
                        state_next = ST_WR_REQ;
                    end else if (rd_ok) begin
                        state_next = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ:  if (sdram_wr_ack)  state_next = ST_WR_BUSY;
            ST_WR_BUSY: if (!sdram_wr_ack) state_next = ST_IDLE;
            ST_RD_REQ:  if (sdram_rd_ack)  state_next = ST_RD_BUSY;
            ST_RD_BUSY: if (!sdram_rd_ack) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output decode: a request is held only while the FSM sits in its REQ state
    always_comb begin
        wr_req_next = (state_next == ST_WR_REQ);
        rd_req_next = (state_next == ST_RD_REQ);
    end

    sdram_addr_gen #(
        .BURST    (WR_BURST),
        .MIN_ADDR (WR_MIN_ADDR),
        .MAX_ADDR (WR_MAX_ADDR)
    ) u_wr_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (wr_load),
        .active      (wr_active),
        .burst_end   (wr_burst_end),
        .offset      (wr_offset),
        .frame_done  (wr_frame_done),
        .wrap_now    (wr_wrap_now),
        .restart_now (wr_restart_now)
    );

    sdram_addr_gen #(
        .BURST    (RD_BURST),
        .MIN_ADDR (RD_MIN_ADDR),
        .MAX_ADDR (RD_MAX_ADDR)
    ) u_rd_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (rd_load),
        .active      (rd_active),
        .burst_end   (rd_burst_end),
        .offset      (rd_offset),
        .frame_done  (rd_frame_done),
        .wrap_now    (rd_wrap_now),
        .restart_now (rd_restart_now)
    );

`ifdef SDRAM_PINGPONG_EN
    logic wr_bank_reg, rd_bank_reg;
    logic unused_events;

    // Bank selectors change together with the offset, so addresses never move mid-burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
        end else begin
            if (wr_wrap_now) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
            if (rd_wrap_now || rd_restart_now) begin
                rd_bank_reg <= ~wr_bank_reg;
            end
        end
    end

    assign unused_events = wr_restart_now;
    assign sdram_wr_addr = {wr_bank_reg, wr_offset};
    assign sdram_rd_addr = {rd_bank_reg, rd_offset};
`else
    logic unused_events;

    assign unused_events = ^{wr_wrap_now, wr_restart_now, rd_wrap_now, rd_restart_now};
    assign sdram_wr_addr = {1'b0, wr_offset};
    assign sdram_rd_addr = {1'b0, rd_offset};
`endif

    assign sdram_wr_req   = wr_req_reg;
    assign sdram_rd_req   = rd_req_reg;
    assign sdram_wr_burst = WR_BURST;
    assign sdram_rd_burst = RD_BURST;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed bench for sdram_rw_arbiter: a scoreboard of expected bursts is
// filled as stimulus is set up and drained as the DUT issues requests.
module tb_sdram_rw_arbiter;

`ifdef SDRAM_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic [9:0]  wr_fifo_level;
    logic [10:0] rd_fifo_level;
    logic        rd_enable;
    logic        wr_load;
    logic        rd_load;
    logic        sdram_wr_req;
    logic        sdram_wr_ack;
    logic [23:0] sdram_wr_addr;
    logic [9:0]  sdram_wr_burst;
    logic        sdram_rd_req;
    logic        sdram_rd_ack;
    logic [23:0] sdram_rd_addr;
    logic [9:0]  sdram_rd_burst;
    logic        wr_frame_done;
    logic        rd_frame_done;

    typedef struct {
        bit          is_read;
        bit          load_mid;
        logic [23:0] addr;
        bit          fd;
    } txn_t;

    txn_t        q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [22:0] mw_off = '0, mr_off = '0;
    logic        mw_bank = 1'b0, mr_bank = 1'b0;

    always #5 clk = ~clk;

    sdram_rw_arbiter #(
        .WR_MAX_ADDR (23'd512),
        .RD_MAX_ADDR (23'd512)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wr_fifo_level   (wr_fifo_level),
        .rd_fifo_level   (rd_fifo_level),
        .rd_enable       (rd_enable),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_wr_burst  (sdram_wr_burst),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_rd_burst  (sdram_rd_burst),
        .wr_frame_done   (wr_frame_done),
        .rd_frame_done   (rd_frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model of the write offset/bank: burst 256, frame end 512
    task automatic expect_write(input bit load_mid);
        txn_t        t;
        logic [23:0] nxt;
        t.is_read  = 1'b0;
        t.load_mid = load_mid;
        t.addr     = {PINGPONG & mw_bank, mw_off};
        nxt        = {1'b0, mw_off} + 24'd256;
        t.fd       = (nxt >= 24'd512);
        if (t.fd) mw_bank = ~mw_bank;
        mw_off = (load_mid || t.fd) ? 23'd0 : nxt[22:0];
        q.push_back(t);
    endtask

    task automatic expect_read(input bit load_mid);
        txn_t        t;
        logic [23:0] nxt;
        t.is_read  = 1'b1;
        t.load_mid = load_mid;
        t.addr     = {PINGPONG & mr_bank, mr_off};
        nxt        = {1'b0, mr_off} + 24'd256;
        t.fd       = (nxt >= 24'd512);
        if (t.fd || load_mid) mr_bank = ~mw_bank;
        mr_off = (load_mid || t.fd) ? 23'd0 : nxt[22:0];
        q.push_back(t);
    endtask

    // Acts as the controller for one burst and checks it against the scoreboard
    task automatic serve_next();
        txn_t t;
        bit   seen;
        check("queue_nonempty", (q.size() > 0), 1);
        if (q.size() == 0) return;
        t    = q.pop_front();
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sdram_wr_req || sdram_rd_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("req_seen", seen, 1);
        if (!seen) return;
        check("req_dir", sdram_rd_req, t.is_read);
        check("req_other", t.is_read ? sdram_wr_req : sdram_rd_req, 0);
        check("req_addr", t.is_read ? sdram_rd_addr : sdram_wr_addr, t.addr);
        if (t.is_read) sdram_rd_ack = 1'b1; else sdram_wr_ack = 1'b1;
        @(negedge clk);
        check("req_drop", t.is_read ? sdram_rd_req : sdram_wr_req, 0);
        if (t.load_mid) begin
            if (t.is_read) rd_load = 1'b1; else wr_load = 1'b1;
        end
        @(negedge clk);
        wr_load = 1'b0;
        rd_load = 1'b0;
        @(negedge clk);
        check("addr_stable", t.is_read ? sdram_rd_addr : sdram_wr_addr, t.addr);
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        @(negedge clk);
        check("frame_done", t.is_read ? rd_frame_done : wr_frame_done, t.fd);
        check("frame_done_other", t.is_read ? wr_frame_done : rd_frame_done, 0);
        $display("txn %s addr=0x%06h load=%0d frame_done=%0d", t.is_read ? "RD" : "WR",
                 t.addr, t.load_mid, t.fd);
    endtask

    initial begin
        bit saw;
        rst_n = 1'b0; sdram_init_done = 1'b0; wr_fifo_level = '0; rd_fifo_level = '0;
        rd_enable = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_req", sdram_wr_req, 0);
        check("rst_rd_req", sdram_rd_req, 0);
        check("rst_wr_addr", sdram_wr_addr, 24'd0);
        check("rst_rd_addr", sdram_rd_addr, 24'd0);
        check("rst_frame_done", {wr_frame_done, rd_frame_done}, 0);
        check("wr_burst", sdram_wr_burst, 10'd256);
        check("rd_burst", sdram_rd_burst, 10'd256);
        rst_n = 1'b1;

        // No grants before controller initialisation
        wr_fifo_level = 10'd300;
        saw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sdram_wr_req || sdram_rd_req) saw = 1'b1;
        end
        check("no_req_before_init", saw, 0);
        expect_write(1'b0);
        sdram_init_done = 1'b1;
        @(negedge clk);
        check("init_wr_req_latency", sdram_wr_req, 1);
        serve_next();

        // Round-robin with both directions eligible: R, W(wrap), R(wrap), W
        rd_enable = 1'b1;
        rd_fifo_level = 11'd0;
        expect_read(1'b0);
        expect_write(1'b0);
        expect_read(1'b0);
        expect_write(1'b0);
        repeat (4) serve_next();

        // Write restart mid-burst: with simultaneous wrap, then alone, then plain
        rd_enable = 1'b0;
        expect_write(1'b1);
        serve_next();
        expect_write(1'b1);
        serve_next();
        expect_write(1'b0);
        serve_next();

        // One read to move the read offset, then an idle read restart
        wr_fifo_level = 10'd0;
        rd_enable = 1'b1;
        expect_read(1'b0);
        serve_next();
        rd_enable = 1'b0;
        rd_load = 1'b1;
        @(negedge clk);
        rd_load = 1'b0;
        mr_off = 23'd0;
        mr_bank = ~mw_bank;
        check("idle_rd_load_addr", sdram_rd_addr, {PINGPONG & mr_bank, mr_off});
        check("idle_rd_load_no_fd", rd_frame_done, 0);

        // Read FIFO room threshold
        rd_fifo_level = 11'd800;
        rd_enable = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sdram_rd_req) saw = 1'b1;
        end
        check("no_rd_req_at_800", saw, 0);
        rd_fifo_level = 11'd768;
        expect_read(1'b0);
        serve_next();

        // Asynchronous reset while a write request is pending
        rd_enable = 1'b0;
        wr_fifo_level = 10'd300;
        saw = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sdram_wr_req) begin
                saw = 1'b1;
                break;
            end
        end
        check("pre_reset_req_seen", saw, 1);
        check("pre_reset_wr_addr", sdram_wr_addr, {PINGPONG & mw_bank, mw_off});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wr_req", sdram_wr_req, 0);
        check("async_rst_rd_req", sdram_rd_req, 0);
        check("async_rst_wr_addr", sdram_wr_addr, 24'd0);
        check("async_rst_rd_addr", sdram_rd_addr, 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mw_off = '0; mr_off = '0; mw_bank = 1'b0; mr_bank = 1'b0;
        expect_write(1'b0);
        serve_next();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
